// File: rtl/d16i_pkg.sv
// d16i_pkg
// Shared constants and types for the d16i register-file write path.
//   DW          : register / write-data width
//   NREGS       : total registers (8 lo bank + 8 hi bank)
//   REG_AW      : register address width (bank bit + index)
//   HI_BANK_BIT : address bit that selects the hi bank
//   state_e     : write-port controller state (INIT clears, ARB arbitrates)
//   req_e       : requester identity, also the encoding of the RR pointer
package d16i_pkg;

    localparam int DW          = 16;
    localparam int NREGS       = 16;
    localparam int REG_AW      = 4;
    localparam int HI_BANK_BIT = 3;

    typedef enum logic {
        INIT = 1'b0,
        ARB  = 1'b1
    } state_e;

    // Index into the req/gnt vectors of the arbiter.
    typedef enum logic {
        REQ_EX  = 1'b0,
        REQ_MEM = 1'b1
    } req_e;

endpackage

// File: rtl/regfile_wr_arb_rr_arb2.sv
// rr_arb2
// Two-way round-robin arbiter. Grant is combinational from req and the
// pointer; the pointer records the most recent winner and moves on every
// grant. On a tie the requester that did NOT win last is granted.
// Ports:
//   clk      : clock
//   rst      : synchronous active-high reset (pointer -> REQ_EX)
//   req[1:0] : request vector, bit index = req_e
//   gnt[1:0] : one-hot (or zero) grant vector, bit index = req_e
module rr_arb2
    import d16i_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    req_e ptr_q;
    req_e ptr_d;

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            // Tie: favour whoever lost last time.
            2'b11:   gnt = (ptr_q == REQ_EX) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt[1]) begin
            ptr_d = REQ_MEM;
        end else if (gnt[0]) begin
            ptr_d = REQ_EX;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= REQ_EX;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_wr_arb.sv
// regfile_wr_arb
// Write-port controller for the 16 x 16-bit register file. After reset it
// writes zero into every register (index 0..15, lo bank first), then shares
// the single write port between the execute (ex) and memory (mem) units with
// round-robin arbitration. Accepted requests appear on the write port one
// cycle after the accepting edge.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   ex_valid/addr/data/ready  : execute-unit write request handshake
//   mem_valid/addr/data/ready : memory-unit write request handshake
//   busy                      : clear sequence in progress
//   sel, sel_lo, sel_hi       : registered write strobe and bank enables
//   sel_gs                    : tied low
//   c_op                      : register index within the bank
//   c_bus                     : write data
module regfile_wr_arb
    import d16i_pkg::*;
#(
    parameter int DW    = 16,
    parameter int NREGS = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ex_valid,
    input  logic [$clog2(NREGS)-1:0]   ex_addr,
    input  logic [DW-1:0]              ex_data,
    output logic                       ex_ready,
    input  logic                       mem_valid,
    input  logic [$clog2(NREGS)-1:0]   mem_addr,
    input  logic [DW-1:0]              mem_data,
    output logic                       mem_ready,
    output logic                       busy,
    output logic                       sel,
    output logic                       sel_lo,
    output logic                       sel_hi,
    output logic                       sel_gs,
    output logic [$clog2(NREGS)-2:0]   c_op,
    output logic [DW-1:0]              c_bus
);

    localparam int AW = $clog2(NREGS);
    // Top address bit picks the bank; the rest is the in-bank index.
    localparam int HI = AW - 1;

    state_e          state_q, state_d;
    // One extra bit: the MSB flags "all indices issued", giving the last
    // clear write its own busy cycle before arbitration starts.
    logic [AW:0]     cnt_q, cnt_d;

    logic            sel_q, sel_d;
    logic            sel_lo_q, sel_lo_d;
    logic            sel_hi_q, sel_hi_d;
    logic [AW-2:0]   c_op_q, c_op_d;
    logic [DW-1:0]   c_bus_q, c_bus_d;

    logic [1:0]      arb_req;
    logic [1:0]      arb_gnt;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;

    // Requests are only visible to the arbiter once the clear sequence is
    // done, so ready stays low and the pointer stays put during INIT.
    assign arb_req = (state_q == ARB) ? {mem_valid, ex_valid} : 2'b00;

    rr_arb2 u_rr_arb2 (
        .clk (clk),
        .rst (rst),
        .req (arb_req),
        .gnt (arb_gnt)
    );

    assign ex_ready  = arb_gnt[REQ_EX];
    assign mem_ready = arb_gnt[REQ_MEM];

    // Next-state and write-source selection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        unique case (state_q)
            INIT: begin
                if (!cnt_q[AW]) begin
                    wr_en   = 1'b1;
                    wr_addr = cnt_q[AW-1:0];
                    cnt_d   = cnt_q + 1'b1;
                end else begin
                    state_d = ARB;
                end
            end
            ARB: begin
                if (arb_gnt[REQ_MEM]) begin
                    wr_en   = 1'b1;
                    wr_addr = mem_addr;
                    wr_data = mem_data;
                end else if (arb_gnt[REQ_EX]) begin
                    wr_en   = 1'b1;
                    wr_addr = ex_addr;
                    wr_data = ex_data;
                end
            end
            default: state_d = INIT;
        endcase
    end

    // Output pipeline stage: strobes drop to zero when nothing was accepted.
    always_comb begin
        sel_d    = wr_en;
        sel_hi_d = wr_en & wr_addr[HI];
        sel_lo_d = wr_en & ~wr_addr[HI];
        c_op_d   = wr_en ? wr_addr[AW-2:0] : '0;
        c_bus_d  = wr_en ? wr_data : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= INIT;
            cnt_q    <= '0;
            sel_q    <= 1'b0;
            sel_lo_q <= 1'b0;
            sel_hi_q <= 1'b0;
            c_op_q   <= '0;
            c_bus_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            sel_lo_q <= sel_lo_d;
            sel_hi_q <= sel_hi_d;
            c_op_q   <= c_op_d;
            c_bus_q  <= c_bus_d;
        end
    end

    assign busy   = (state_q == INIT);
    assign sel    = sel_q;
    assign sel_lo = sel_lo_q;
    assign sel_hi = sel_hi_q;
    assign sel_gs = 1'b0;
    assign c_op   = c_op_q;
    assign c_bus  = c_bus_q;

endmodule

// File: tb/tb_regfile_wr_arb.sv
// tb_regfile_wr_arb
// Scoreboard bench: the stimulus side predicts ready and the resulting
// register-file writes from the behavioural rules (init clears, who wins a
// request, tie goes to whoever did not win last) and queues the expected
// writes with the cycle they must appear in; a negedge monitor pops and
// compares everything seen on the write port.
module tb_regfile_wr_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic [3:0]  ex_addr = '0;
    logic [15:0] ex_data = '0;
    logic        ex_ready;
    logic        mem_valid = 1'b0;
    logic [3:0]  mem_addr = '0;
    logic [15:0] mem_data = '0;
    logic        mem_ready;
    logic        busy, sel, sel_lo, sel_hi, sel_gs;
    logic [2:0]  c_op;
    logic [15:0] c_bus;

    regfile_wr_arb #(.DW(16), .NREGS(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .ex_valid  (ex_valid),
        .ex_addr   (ex_addr),
        .ex_data   (ex_data),
        .ex_ready  (ex_ready),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .busy      (busy),
        .sel       (sel),
        .sel_lo    (sel_lo),
        .sel_hi    (sel_hi),
        .sel_gs    (sel_gs),
        .c_op      (c_op),
        .c_bus     (c_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [3:0]  addr;
        logic [15:0] data;
    } exp_t;

    exp_t exp_q[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    // Model state.
    localparam int NEVER = 32'h7fff_ffff;
    int check_from = NEVER;   // first cycle the monitor checks
    int busy_until = NEVER;   // last cycle busy is expected high
    int rel_cyc    = NEVER;   // last cycle of the reset-state window
    bit last_mem   = 1'b0;    // most recent winner was mem
    bit acc_ex, acc_mem;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compare the write port against the scoreboard every cycle.
    always @(negedge clk) begin
        if (cyc >= check_from) begin
            chk("busy", 32'(busy), 32'(cyc <= busy_until));
            chk("sel_gs", 32'(sel_gs), 32'd0);
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                chk("missed_write", 32'(exp_q[0].cyc), 32'(cyc));
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                $display("write cyc=%0d addr=%h data=%h", cyc, e.addr, e.data);
                chk("sel", 32'(sel), 32'd1);
                chk("sel_hi", 32'(sel_hi), 32'(e.addr[3]));
                chk("sel_lo", 32'(sel_lo), 32'(!e.addr[3]));
                chk("c_op", 32'(c_op), 32'(e.addr[2:0]));
                chk("c_bus", 32'(c_bus), 32'(e.data));
            end else begin
                chk("sel_idle", 32'({sel, sel_lo, sel_hi}), 32'd0);
            end
            if (cyc <= rel_cyc) begin
                chk("rst_c_op", 32'(c_op), 32'd0);
                chk("rst_c_bus", 32'(c_bus), 32'd0);
                chk("rst_ready", 32'({ex_ready, mem_ready}), 32'd0);
            end
        end
    end

    // Raise reset within the current cycle; anything not yet on the port is lost.
    task automatic assert_rst();
        rst        = 1'b1;
        ex_valid   = 1'b0;
        mem_valid  = 1'b0;
        exp_q.delete();
        check_from = cyc + 1;
        busy_until = NEVER;
        rel_cyc    = NEVER;
        last_mem   = 1'b0;
    endtask

    task automatic release_rst(input int n);
        repeat (n) @(posedge clk);
        #1;
        rst        = 1'b0;
        rel_cyc    = cyc;
        busy_until = cyc + 16;
        for (int i = 0; i < 16; i++) begin
            exp_t e;
            e.cyc  = cyc + 1 + i;
            e.addr = 4'(i);
            e.data = 16'h0000;
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        assert_rst();
        release_rst(n);
    endtask

    // One cycle of stimulus plus the reference decision for that cycle.
    task automatic step(input logic ev, input logic [3:0] ea, input logic [15:0] ed,
                        input logic mv, input logic [3:0] ma, input logic [15:0] md);
        bit arb, g_ex, g_mem;
        exp_t e;
        @(posedge clk);
        #1;
        ex_valid  = ev;
        ex_addr   = ea;
        ex_data   = ed;
        mem_valid = mv;
        mem_addr  = ma;
        mem_data  = md;
        #1;
        arb   = (cyc > busy_until);
        g_ex  = arb && ev && (!mv || last_mem);
        g_mem = arb && mv && (!ev || !last_mem);
        chk("ex_ready", 32'(ex_ready), 32'(g_ex));
        chk("mem_ready", 32'(mem_ready), 32'(g_mem));
        acc_ex  = g_ex;
        acc_mem = g_mem;
        if (g_ex || g_mem) begin
            e.cyc  = cyc + 1;
            e.addr = g_mem ? ma : ea;
            e.data = g_mem ? md : ed;
            exp_q.push_back(e);
            last_mem = g_mem;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 16'h0);
    endtask

    // Random traffic; an unaccepted request either holds its payload or drops.
    task automatic run_random(input int n, input int pe, input int pm);
        logic ev = 1'b0, mv = 1'b0;
        logic [3:0] ea = '0, ma = '0;
        logic [15:0] ed = '0, md = '0;
        for (int i = 0; i < n; i++) begin
            if (ev && !acc_ex) begin
                if ($urandom_range(0, 9) == 0) ev = 1'b0;
            end else begin
                ev = ($urandom_range(0, 99) < pe);
                ea = 4'($urandom);
                ed = 16'($urandom);
            end
            if (mv && !acc_mem) begin
                if ($urandom_range(0, 9) == 0) mv = 1'b0;
            end else begin
                mv = ($urandom_range(0, 99) < pm);
                ma = 4'($urandom);
                md = 16'($urandom);
            end
            step(ev, ea, ed, mv, ma, md);
        end
    endtask

    initial begin
        acc_ex  = 1'b0;
        acc_mem = 1'b0;

        // Reset release and the full clear sequence.
        do_reset(3);
        idle(18);

        // Single ex write to the hi bank, index 2.
        step(1'b1, 4'hA, 16'h1234, 1'b0, 4'h0, 16'h0);
        idle(2);
        // mem alone, then a tie that ex wins, then mem drops its request.
        step(1'b0, 4'h0, 16'h0, 1'b1, 4'h3, 16'hBEEF);
        step(1'b1, 4'h5, 16'h0555, 1'b1, 4'hC, 16'hCAFE);
        step(1'b1, 4'h6, 16'h0666, 1'b0, 4'hC, 16'hCAFE);
        // Idle leaves the pointer alone: next tie goes to mem.
        idle(4);
        step(1'b1, 4'h1, 16'h1111, 1'b1, 4'h9, 16'h9999);
        idle(2);

        // Continuous contention straight after init: mem, ex, mem, ex.
        do_reset(1);
        idle(17);
        run_random(4, 100, 100);
        idle(2);

        // Reset while clear index 7 is on the port.
        do_reset(2);
        idle(7);
        do_reset(1);
        idle(18);

        // Randomized traffic at several loads.
        run_random(500, 50, 50);
        run_random(400, 90, 90);
        run_random(300, 20, 80);
        run_random(300, 80, 20);

        // Reset on the same edge as an acceptance: that write never appears.
        step(1'b1, 4'h7, 16'h7777, 1'b1, 4'hF, 16'hFFFF);
        assert_rst();
        release_rst(2);
        idle(18);
        run_random(200, 60, 60);
        idle(3);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
